dac_spi_tx: RTL and testbench



---
 rtl/dac_spi_pkg.sv | 15 +
 rtl/spi_clk_div.sv | 44 ++++
 rtl/dac_spi_tx.sv | 154 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and default sizing for the serial DAC output stage.
package dac_spi_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int CLK_DIV_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI clock: tick every CLK_DIV enabled cycles,
// split into rise/fall strobes by the current sclk level.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic sclk,
   output logic tick,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   // Held at the reload value while idle so the first tick lands exactly
   // CLK_DIV cycles after the frame opens.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = RELOAD;
      end else if (cnt_q == 8'd0) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == 8'd0);
   assign rise = tick && !sclk;
   assign fall = tick && sclk;

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 frame transmitter feeding the external DAC, MSB first.
// Define DAC_SPI_TX_OFFSET_BIN_EN to send offset binary (MSB inverted).
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              sclk,
   output logic              mosi,
   output logic              cs_n,
   output logic              busy,
   output logic              frame_done
);

   localparam int            BW   = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_W);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [DATA_W-1:0] word;
   logic [BW-1:0]     bit_q, bit_d;
   logic              s_ready_q, s_ready_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;
   logic              div_en, tick, rise, fall;

   assign div_en = (state_q != IDLE);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (div_en),
      .sclk  (sclk_q),
      .tick  (tick),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      word = s_data;
`ifdef DAC_SPI_TX_OFFSET_BIN_EN
      word[DATA_W-1] = ~s_data[DATA_W-1];
`endif
   end

   assign accept = s_valid && s_ready_q;

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bit_d     = bit_q;
      s_ready_d = s_ready_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sreg_d    = word;
               bit_d     = '0;
               cs_n_d    = 1'b0;
               s_ready_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               sclk_d  = 1'b1;
               bit_d   = BW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // The low half after the last falling edge still belongs here.
            if (rise) begin
               if (bit_q == LAST) begin
                  state_d = HOLD;
               end else begin
                  sclk_d = 1'b1;
                  bit_d  = bit_q + BW'(1);
               end
            end else if (fall) begin
               sclk_d = 1'b0;
               if (bit_q != LAST) begin
                  sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               sreg_d  = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (tick) begin
               s_ready_d = 1'b1;
               busy_d    = 1'b0;
               bit_d     = '0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         bit_q     <= '0;
         s_ready_q <= 1'b1;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         bit_q     <= bit_d;
         s_ready_q <= s_ready_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // mosi is the shift register MSB, so it is registered and clears with it.
   assign s_ready    = s_ready_q;
   assign sclk       = sclk_q;
   assign mosi       = sreg_q[DATA_W-1];
   assign cs_n       = cs_n_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1), a wire-side
// monitor decoding each frame and a queue of expected words per instance.
module tb_dac_spi_tx;

`ifdef DAC_SPI_TX_OFFSET_BIN_EN
   localparam logic [15:0] OB = 16'h8000;
`else
   localparam logic [15:0] OB = 16'h0000;
`endif

   typedef struct {
      int          k;
      logic [15:0] d;
      logic [15:0] w;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_data_a [2];
   logic        s_valid_a[2];
   logic        s_ready_a[2];
   logic        sclk_a   [2];
   logic        mosi_a   [2];
   logic        cs_n_a   [2];
   logic        busy_a   [2];
   logic        done_a   [2];

   int unsigned cyc = 0;
   int          checks = 0;
   int          passes = 0;

   logic [15:0] exp_q[2][$];
   logic [15:0] bits    [2];
   int          nbits   [2];
   int          low_cnt [2];
   int          frames  [2];
   int          done_cnt[2];
   logic        prev_s  [2];
   logic        prev_c  [2];

   vec_t vecs[5];

   always #5 clk = ~clk;

   dac_spi_tx #(.DATA_W(16), .CLK_DIV(2)) u_a (
      .clk        (clk),
      .reset      (rst),
      .s_data     (s_data_a[0]),
      .s_valid    (s_valid_a[0]),
      .s_ready    (s_ready_a[0]),
      .sclk       (sclk_a[0]),
      .mosi       (mosi_a[0]),
      .cs_n       (cs_n_a[0]),
      .busy       (busy_a[0]),
      .frame_done (done_a[0])
   );

   dac_spi_tx #(.DATA_W(16), .CLK_DIV(1)) u_b (
      .clk        (clk),
      .reset      (rst),
      .s_data     (s_data_a[1]),
      .s_valid    (s_valid_a[1]),
      .s_ready    (s_ready_a[1]),
      .sclk       (sclk_a[1]),
      .mosi       (mosi_a[1]),
      .cs_n       (cs_n_a[1]),
      .busy       (busy_a[1]),
      .frame_done (done_a[1])
   );

   function automatic int div_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Wire-side monitor: sample on the falling clk edge, collect mosi on each
   // sclk rise, and close the frame when cs_n returns high.
   initial begin
      for (int k = 0; k < 2; k++) begin
         frames[k]   = 0;
         done_cnt[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               bits[k]    = '0;
               nbits[k]   = 0;
               low_cnt[k] = 0;
               prev_s[k]  = 1'b0;
               prev_c[k]  = 1'b1;
               exp_q[k].delete();
            end else begin
               if (done_a[k]) done_cnt[k]++;
               if (!cs_n_a[k]) begin
                  low_cnt[k]++;
                  if (sclk_a[k] && !prev_s[k]) begin
                     bits[k] = {bits[k][14:0], mosi_a[k]};
                     nbits[k]++;
                  end
               end else if (!prev_c[k]) begin
                  check("frame_done_at_cs_rise", done_a[k], 1);
                  check("rise_count", nbits[k], 16);
                  check("cs_low_cycles", low_cnt[k], 34 * div_of(k));
                  check("frame_expected", exp_q[k].size() > 0, 1);
                  if (exp_q[k].size() > 0)
                     check("wire_word", bits[k], exp_q[k].pop_front());
                  frames[k]++;
                  bits[k]    = '0;
                  nbits[k]   = 0;
                  low_cnt[k] = 0;
               end
               prev_s[k] = sclk_a[k];
               prev_c[k] = cs_n_a[k];
            end
         end
      end
   end

   task automatic send(input int k, input logic [15:0] d,
                       input logic [15:0] e, output int unsigned acc);
      int n = 0;
      @(negedge clk);
      s_data_a[k]  = d;
      s_valid_a[k] = 1'b1;
      while (!s_ready_a[k] && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", n < 300, 1);
      acc = cyc + 1;
      exp_q[k].push_back(e);
      @(negedge clk);
   endtask

   task automatic wait_frames(input int k, input int target);
      int n = 0;
      while (frames[k] < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("frame_timeout", n < 400, 1);
   endtask

   initial begin
      int unsigned a1, a2;
      int          f, n;
      for (int k = 0; k < 2; k++) begin
         s_data_a[k]  = '0;
         s_valid_a[k] = 1'b0;
      end
      vecs[0] = '{0, 16'hA5C3, 16'hA5C3 ^ OB};
      vecs[1] = '{0, 16'h0000, OB};
      vecs[2] = '{1, 16'hFFFF, 16'hFFFF ^ OB};
      vecs[3] = '{1, 16'h3C96, 16'h3C96 ^ OB};
      vecs[4] = '{0, 16'h8001, 16'h8001 ^ OB};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++)
         check("reset_outputs",
               {s_ready_a[k], sclk_a[k], mosi_a[k], cs_n_a[k],
                busy_a[k], done_a[k]}, 6'b100100);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         f = frames[vecs[i].k];
         send(vecs[i].k, vecs[i].d, vecs[i].w, a1);
         s_valid_a[vecs[i].k] = 1'b0;
         wait_frames(vecs[i].k, f + 1);
      end

      // back-to-back with s_valid held: second sample waits, is not lost
      f = frames[0];
      send(0, 16'h0001, 16'h0001 ^ OB, a1);
      send(0, 16'h0002, 16'h0002 ^ OB, a2);
      s_valid_a[0] = 1'b0;
      check("b2b_accept_spacing", a2 - a1, 71);
      wait_frames(0, f + 2);

      // stray one-cycle s_valid while busy
      f = frames[0];
      send(0, 16'h5A5A, 16'h5A5A ^ OB, a1);
      s_valid_a[0] = 1'b0;
      repeat (10) @(negedge clk);
      s_data_a[0]  = 16'h1234;
      s_valid_a[0] = 1'b1;
      @(negedge clk);
      s_valid_a[0] = 1'b0;
      wait_frames(0, f + 1);
      repeat (100) @(negedge clk);
      check("no_frame_for_stray", frames[0], f + 1);
      check("cs_idle_after_stray", cs_n_a[0], 1);

      // asynchronous reset in the middle of SHIFT
      f = frames[0];
      send(0, 16'hF0F0, 16'hF0F0 ^ OB, a1);
      s_valid_a[0] = 1'b0;
      n = 0;
      while (nbits[0] < 8 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit7", n < 200, 1);
      check("mid_frame_active", {busy_a[0], cs_n_a[0]}, 2'b10);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs",
               {s_ready_a[0], sclk_a[0], mosi_a[0], cs_n_a[0],
                busy_a[0], done_a[0]}, 6'b100100);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("aborted_not_counted", frames[0], f);
      send(0, 16'h0F0F, 16'h0F0F ^ OB, a1);
      s_valid_a[0] = 1'b0;
      wait_frames(0, f + 1);

      repeat (5) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("done_pulses", done_cnt[k], frames[k]);
         check("queue_drained", exp_q[k].size(), 0);
      end
      check("frames_a", frames[0], 7);
      check("frames_b", frames[1], 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
